qec_stage_controller: RTL and testbench

- Global decoder sequencer. It sits directly upstream of the processing-unit array and drives the shared global_stage bus.
- It collects per-PU busy/odd flags and decides when each union-find phase has converged: measurement load, grow/merge iterations, then peeling.
- It provides a start/result handshake to the host-side round controller and reports iteration and cycle statistics.

---
 rtl/qec_stage_controller_pkg.sv | 23 ++
 rtl/qec_stage_controller_convergence_detector.sv | 65 ++++++
 rtl/qec_stage_controller.sv | 106 ++++++++++
 tb/tb_qec_stage_controller.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/qec_stage_controller_pkg.sv
// Shared stage encodings for the decoder sequencer and the processing-unit array.
// The PU array decodes global_stage using exactly these values.
package qec_stage_controller_pkg;

  localparam int STAGE_WIDTH = 3;

  typedef enum logic [STAGE_WIDTH-1:0] {
    STAGE_IDLE                  = 3'd0,
    STAGE_MEASUREMENT_PREPARING = 3'd1,
    STAGE_MEASUREMENT_LOADING   = 3'd2,
    STAGE_GROW                  = 3'd3,
    STAGE_MERGE                 = 3'd4,
    STAGE_PEELING               = 3'd5,
    STAGE_RESULT_VALID          = 3'd6,
    STAGE_ERASURE_LOADING       = 3'd7
  } stage_e;

  // Stages whose length is set by the PU array settling rather than a fixed count
  function automatic logic is_settle_stage(input logic [STAGE_WIDTH-1:0] stage);
    return (stage == STAGE_MERGE) || (stage == STAGE_PEELING);
  endfunction

endpackage

// File: rtl/qec_stage_controller_convergence_detector.sv
// Reduces per-PU busy/odd flags and decides when a MERGE/PEELING phase has settled.
// converged is combinational so the sequencer can leave the phase in the same cycle.
module qec_stage_controller_convergence_detector
  import qec_stage_controller_pkg::*;
#(
  parameter int PU_COUNT     = 64,
  parameter int QUIET_CYCLES = 2,
  parameter int PIPE_DELAY   = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [STAGE_WIDTH-1:0] stage,
  input  logic [PU_COUNT-1:0]    busy_in,
  input  logic [PU_COUNT-1:0]    odd_in,
  output logic                   converged,
  output logic                   odd_any_r
);

  localparam int CNT_WIDTH = 8;

  logic                   busy_any_r;
  logic [STAGE_WIDTH-1:0] stage_prev_r;
  logic [CNT_WIDTH-1:0]   stage_cnt_r;
  logic [CNT_WIDTH-1:0]   quiet_cnt_r;
  logic                   stage_change_s;
  logic [CNT_WIDTH-1:0]   stage_cnt_s;
  logic [CNT_WIDTH-1:0]   quiet_next_s;

  // Stage age and quiet-window bookkeeping; flags are stale until PIPE_DELAY cycles in
  always_comb begin
    stage_change_s = (stage != stage_prev_r);
    stage_cnt_s    = stage_change_s ? {CNT_WIDTH{1'b0}} : stage_cnt_r;
    quiet_next_s   = {CNT_WIDTH{1'b0}};
    if (!is_settle_stage(stage) || stage_change_s ||
        (stage_cnt_s < CNT_WIDTH'(PIPE_DELAY))) begin
      quiet_next_s = {CNT_WIDTH{1'b0}};
    end else if (busy_any_r) begin
      quiet_next_s = {CNT_WIDTH{1'b0}};
    end else if (quiet_cnt_r < CNT_WIDTH'(QUIET_CYCLES)) begin
      quiet_next_s = quiet_cnt_r + CNT_WIDTH'(1);
    end else begin
      quiet_next_s = quiet_cnt_r;
    end
    converged = is_settle_stage(stage) && (quiet_next_s == CNT_WIDTH'(QUIET_CYCLES));
  end

  // Registered reductions and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_any_r   <= 1'b0;
      odd_any_r    <= 1'b0;
      stage_prev_r <= STAGE_IDLE;
      stage_cnt_r  <= {CNT_WIDTH{1'b0}};
      quiet_cnt_r  <= {CNT_WIDTH{1'b0}};
    end else begin
      busy_any_r   <= |busy_in;
      odd_any_r    <= |odd_in;
      stage_prev_r <= stage;
      stage_cnt_r  <= (stage_cnt_s == {CNT_WIDTH{1'b1}}) ? stage_cnt_s
                                                          : stage_cnt_s + CNT_WIDTH'(1);
      quiet_cnt_r  <= quiet_next_s;
    end
  end

endmodule

// File: rtl/qec_stage_controller.sv
// Global union-find decoder sequencer: drives global_stage, runs grow/merge iterations
// until no odd clusters remain, then peeling, and hands the round result to the host.
module qec_stage_controller
  import qec_stage_controller_pkg::*;
#(
  parameter int PU_COUNT       = 64,
  parameter int QUIET_CYCLES   = 2,
  parameter int PIPE_DELAY     = 3,
  parameter int MAX_ITERATIONS = 31,
  parameter int ITER_WIDTH     = 5,
  parameter int CYCLE_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   new_round_start,
  input  logic                   result_ready,
  input  logic [PU_COUNT-1:0]    busy_in,
  input  logic [PU_COUNT-1:0]    odd_in,
  output logic [STAGE_WIDTH-1:0] global_stage,
  output logic                   result_valid,
  output logic [ITER_WIDTH-1:0]  iteration_count,
  output logic [CYCLE_WIDTH-1:0] cycle_count,
  output logic                   overflow
);

  stage_e state_r;
  logic   converged;
  logic   odd_any_r;

  assign global_stage = state_r;

  qec_stage_controller_convergence_detector #(
    .PU_COUNT     (PU_COUNT),
    .QUIET_CYCLES (QUIET_CYCLES),
    .PIPE_DELAY   (PIPE_DELAY)
  ) u_convergence_detector (
    .clk       (clk),
    .reset     (reset),
    .stage     (state_r),
    .busy_in   (busy_in),
    .odd_in    (odd_in),
    .converged (converged),
    .odd_any_r (odd_any_r)
  );

  // Phase sequencer with round statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= STAGE_IDLE;
      result_valid    <= 1'b0;
      iteration_count <= {ITER_WIDTH{1'b0}};
      cycle_count     <= {CYCLE_WIDTH{1'b0}};
      overflow        <= 1'b0;
    end else begin
      if ((state_r != STAGE_IDLE) && (state_r != STAGE_RESULT_VALID) &&
          (cycle_count != {CYCLE_WIDTH{1'b1}})) begin
        cycle_count <= cycle_count + CYCLE_WIDTH'(1);
      end
      case (state_r)
        STAGE_IDLE: begin
          iteration_count <= {ITER_WIDTH{1'b0}};
          cycle_count     <= {CYCLE_WIDTH{1'b0}};
          overflow        <= 1'b0;
          if (new_round_start) begin
            state_r <= STAGE_MEASUREMENT_PREPARING;
          end
        end
        STAGE_MEASUREMENT_PREPARING: state_r <= STAGE_MEASUREMENT_LOADING;
        STAGE_MEASUREMENT_LOADING:   state_r <= STAGE_MERGE;
        STAGE_GROW:                  state_r <= STAGE_MERGE;
        STAGE_MERGE: begin
          if (converged) begin
            if (!odd_any_r) begin
              state_r <= STAGE_PEELING;
            end else if (iteration_count < ITER_WIDTH'(MAX_ITERATIONS)) begin
              state_r         <= STAGE_GROW;
              iteration_count <= iteration_count + ITER_WIDTH'(1);
            end else begin
              // Iteration budget exhausted: report without peeling
              overflow     <= 1'b1;
              state_r      <= STAGE_RESULT_VALID;
              result_valid <= 1'b1;
            end
          end
        end
        STAGE_PEELING: begin
          if (converged) begin
            state_r      <= STAGE_RESULT_VALID;
            result_valid <= 1'b1;
          end
        end
        STAGE_RESULT_VALID: begin
          if (result_ready) begin
            state_r      <= STAGE_IDLE;
            result_valid <= 1'b0;
          end
        end
        default: begin
          state_r      <= STAGE_IDLE;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qec_stage_controller.sv
// Randomized scoreboard bench: a PU-array responder follows a per-round plan, a
// phase-level model predicts the round statistics, and a monitor checks each result.
module tb_qec_stage_controller;
  import qec_stage_controller_pkg::*;

  localparam int PU   = 64;
  localparam int QC   = 2;
  localparam int PD   = 3;
  localparam int MAXI = 31;
  localparam int IW   = 5;
  localparam int CW   = 16;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   new_round_start;
  logic                   result_ready;
  logic [PU-1:0]          busy_in;
  logic [PU-1:0]          odd_in;
  logic [STAGE_WIDTH-1:0] global_stage;
  logic                   result_valid;
  logic [IW-1:0]          iteration_count;
  logic [CW-1:0]          cycle_count;
  logic                   overflow;

  qec_stage_controller #(
    .PU_COUNT(PU), .QUIET_CYCLES(QC), .PIPE_DELAY(PD),
    .MAX_ITERATIONS(MAXI), .ITER_WIDTH(IW), .CYCLE_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .new_round_start(new_round_start),
    .result_ready(result_ready), .busy_in(busy_in), .odd_in(odd_in),
    .global_stage(global_stage), .result_valid(result_valid),
    .iteration_count(iteration_count), .cycle_count(cycle_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct { int iters; int cyc; int ovf; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Round plan read by the PU-array responder: bit c of a mask means busy is seen
  // by the controller in cycle c of that phase
  int          plan_k = 0;
  int          odd_bit = 0;
  logic [31:0] plan_merge [0:63];
  logic [31:0] plan_peel = 32'h0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Cycles a settle phase lasts: ends once QC consecutive quiet cycles follow the stale window
  function automatic int phase_len(input logic [31:0] m);
    int q = 0;
    for (int c = 0; c < 64; c++) begin
      if (c < PD) q = 0;
      else if (c < 32 && m[c]) q = 0;
      else q++;
      if (q == QC) return c + 1;
    end
    return 64;
  endfunction

  function automatic logic [31:0] rand_mask();
    logic [31:0] m;
    m = $urandom & 32'h0000_0007;
    if ($urandom_range(0, 2) == 0) m = m | (32'h1 << $urandom_range(3, 11));
    if ($urandom_range(0, 3) == 0) m = m | (32'h1 << $urandom_range(3, 11));
    return m;
  endfunction

  // mode 0: random masks, 1: late busy in first merge + stale busy in peeling, 2: all quiet
  task automatic make_plan(input int k, input int mode, output exp_t e);
    int iters;
    plan_k  = k;
    odd_bit = $urandom_range(0, PU - 1);
    for (int i = 0; i < 64; i++) plan_merge[i] = (mode == 0) ? rand_mask() : 32'h0;
    plan_peel = (mode == 0) ? rand_mask() : 32'h0;
    if (mode == 1) begin
      plan_merge[0] = 32'h0000_0010;
      plan_peel     = 32'h0000_0007;
    end
    iters = (k > MAXI) ? MAXI : k;
    e.iters = iters;
    e.ovf   = (k > MAXI) ? 1 : 0;
    e.cyc   = 2 + iters;
    for (int i = 0; i <= iters; i++) e.cyc += phase_len(plan_merge[i]);
    if (e.ovf == 0) e.cyc += phase_len(plan_peel);
    if (e.cyc > 65535) e.cyc = 65535;
  endtask

  task automatic run_round(input int k, input int mode);
    exp_t e;
    int n;
    make_plan(k, mode, e);
    exp_q.push_back(e);
    new_round_start = 1'b1;
    @(posedge clk); #1;
    new_round_start = 1'b0;
    n = 0;
    while (!result_valid && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!result_valid) begin
      checks++; errors++;
      $display("FAIL round_timeout: got no result_valid after %0d cycles expected a result", n);
      void'(exp_q.pop_back());
      reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    end else begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      result_ready = 1'b1;
      @(posedge clk); #1;
      result_ready = 1'b0;
      chk("idle_after_accept", global_stage, STAGE_IDLE);
    end
  endtask

  // PU-array responder: tracks the stage from global_stage and drives busy/odd per plan
  initial begin : pu_array
    logic [STAGE_WIDTH-1:0] prev;
    int c, j;
    logic b;
    busy_in = '0; odd_in = '0; prev = STAGE_IDLE; c = 0; j = 0;
    forever begin
      @(posedge clk); #1;
      if (global_stage != prev) begin
        c = 0;
        if (global_stage == STAGE_MERGE) j++;
      end else begin
        c++;
      end
      if (global_stage == STAGE_IDLE) j = 0;
      prev = global_stage;
      busy_in = '0; odd_in = '0; b = 1'b0;
      if (global_stage == STAGE_MERGE && j >= 1 && j <= 64) begin
        if (j - 1 < plan_k) odd_in[odd_bit] = 1'b1;
        b = (c + 1 < 32) && plan_merge[j-1][c+1];
      end else if (global_stage == STAGE_PEELING) begin
        b = (c + 1 < 32) && plan_peel[c+1];
      end
      if (b) begin
        if ($urandom_range(0, 1) == 1) busy_in = '1;
        else busy_in[$urandom_range(0, PU - 1)] = 1'b1;
      end
    end
  end

  // Monitor: pops one expectation per presented result and checks it stays frozen
  initial begin : monitor
    exp_t cur;
    bit held;
    held = 0;
    cur = '{0, 0, 0};
    forever begin
      @(negedge clk);
      if (reset || !result_valid) begin
        held = 0;
      end else if (!held) begin
        held = 1;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got result_valid=1 expected no pending round");
        end else begin
          cur = exp_q.pop_front();
          chk("result_iterations", iteration_count, cur.iters);
          chk("result_cycles", cycle_count, cur.cyc);
          chk("result_overflow", overflow, cur.ovf);
          chk("result_stage", global_stage, STAGE_RESULT_VALID);
        end
      end else begin
        chk("cycles_frozen", cycle_count, cur.cyc);
      end
    end
  end

  initial begin : stimulus
    exp_t e;
    int exp_stage;
    reset = 1'b1; new_round_start = 1'b0; result_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_stage", global_stage, STAGE_IDLE);
    chk("reset_valid", result_valid, 0);
    chk("reset_iterations", iteration_count, 0);
    chk("reset_cycles", cycle_count, 0);
    chk("reset_overflow", overflow, 0);

    // Zero syndrome with an exact stage trace; start held during RESULT_VALID is ignored
    make_plan(0, 2, e);
    exp_q.push_back(e);
    new_round_start = 1'b1;
    for (int t = 1; t <= 16; t++) begin
      @(posedge clk); #1;
      if (t == 1) new_round_start = 1'b0;
      if (t == 13) new_round_start = 1'b1;
      if (t == 15) begin new_round_start = 1'b0; result_ready = 1'b1; end
      if (t == 16) result_ready = 1'b0;
      exp_stage = (t == 1) ? STAGE_MEASUREMENT_PREPARING :
                  (t == 2) ? STAGE_MEASUREMENT_LOADING :
                  (t <= 7) ? STAGE_MERGE :
                  (t <= 12) ? STAGE_PEELING :
                  (t <= 15) ? STAGE_RESULT_VALID : STAGE_IDLE;
      chk($sformatf("zero_trace_c%0d", t), global_stage, exp_stage);
    end

    run_round(0, 1);
    run_round(2, 2);
    run_round(2, 1);

    // Abort mid-round with start asserted alongside reset
    make_plan(3, 0, e);
    new_round_start = 1'b1;
    @(posedge clk); #1;
    new_round_start = 1'b0;
    repeat ($urandom_range(6, 20)) @(posedge clk);
    #1;
    reset = 1'b1; new_round_start = 1'b1;
    @(posedge clk); #1;
    chk("abort_stage", global_stage, STAGE_IDLE);
    chk("abort_valid", result_valid, 0);
    chk("abort_iterations", iteration_count, 0);
    chk("abort_cycles", cycle_count, 0);
    chk("abort_overflow", overflow, 0);
    reset = 1'b0; new_round_start = 1'b0;
    @(posedge clk); #1;
    chk("start_with_reset_ignored", global_stage, STAGE_IDLE);

    for (int r = 0; r < 20; r++) run_round($urandom_range(0, 4), 0);
    run_round(MAXI - 1, 0);
    run_round(MAXI, 0);
    run_round(MAXI + 1, 0);
    run_round(MAXI + 2, 2);
    run_round(1, 0);

    repeat (5) @(posedge clk);
    #1;
    chk("all_results_seen", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
